// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input vector to a combinational DUT and compares against a golden table.
// Latency: each vector takes SETTLE+1 cycles; DONE is entered 2^N_IN*(SETTLE+1) cycles after the start edge (fewer on early stop).
// Backpressure: none; start is only honoured in IDLE and is ignored (not queued) while a sweep or its done cycle is in progress.
module tt_sweep_checker #(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 3,
    parameter int SETTLE      = 1,
    parameter int STOP_ON_ERR = 0,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int NVEC = 2 ** N_IN;

    // Last vector of a sweep; the vector counter never wraps past it.
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    // Error counter ceiling: one error per vector at most.
    localparam logic [N_IN:0] ERR_MAX = (N_IN + 1)'(NVEC);

    // Settle counter value on the final HOLD cycle of a vector.
    localparam logic [3:0] HOLD_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With no settle time a vector is sampled in the same cycle it is driven,
    // so HOLD is bypassed to keep each vector exactly SETTLE+1 cycles long.
    localparam state_t LOAD_ST = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ferr_vec_q, ferr_vec_d;
    logic              ferr_vld_q, ferr_vld_d;
    logic              pass_q, pass_d;

    logic [N_OUT-1:0]  exp_tab [NVEC];
    logic              mismatch;

    // Unpack the flat golden table into one entry per vector.
    for (genvar gv = 0; gv < NVEC; gv++) begin : g_tab
        assign exp_tab[gv] = EXPECTED[gv*N_OUT +: N_OUT];
    end

    assign mismatch = (state_q == ST_SAMPLE) && (dut_out != exp_tab[vec_q]);

    // Sweep sequencing, result accumulation and pass latching.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ferr_vec_d = ferr_vec_q;
        ferr_vld_d = ferr_vld_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d      = '0;
                    ferr_vec_d = '0;
                    ferr_vld_d = 1'b0;
                    pass_d     = 1'b0;
                    vec_d      = '0;
                    cnt_d      = '0;
                    state_d    = LOAD_ST;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ferr_vld_q) begin
                        ferr_vec_d = vec_q;
                        ferr_vld_d = 1'b1;
                    end
                end
                if ((vec_q == LAST_VEC) || ((STOP_ON_ERR != 0) && mismatch)) begin
                    // pass is settled on DONE entry so it is valid alongside done
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = LOAD_ST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; synchronous reset overrides start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            ferr_vec_q <= '0;
            ferr_vld_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ferr_vec_q <= ferr_vec_d;
            ferr_vld_q <= ferr_vld_d;
            pass_q     <= pass_d;
        end
    end

    assign dut_in          = vec_q;
    assign busy            = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_vec   = ferr_vec_q;
    assign first_err_valid = ferr_vld_q;

endmodule
